// File: rtl/rot_seq.sv
// Motor rotation sequencer: runs reversing wash jobs (CW/P1/CCW/P2 x N) or a single CW spin run.
// Optional `ROT_SEQ_REV_GUARD_EN inserts one stop cycle between direct CW<->CCW reversals.
//
// state | meaning
// IDLE  | no job; motor stopped, done pulses here after a completed job
// CW    | clockwise run phase
// P1    | pause after CW
// CCW   | counter-clockwise run phase
// P2    | pause after CCW, end of one repetition
// GUARD | single stop cycle between direct reversals (guard build only)
module rot_seq #(
  parameter int MOTOR_W = 2,
  parameter int CNT_W   = 4,
  parameter int REP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               spin,
  input  logic [CNT_W-1:0]   cw_len,
  input  logic [CNT_W-1:0]   ccw_len,
  input  logic [CNT_W-1:0]   pause_len,
  input  logic [REP_W-1:0]   rep_num,
  output logic [MOTOR_W-1:0] motor,
  output logic               busy,
  output logic               done,
  output logic [REP_W-1:0]   rep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CW    = 3'd1,
    S_P1    = 3'd2,
    S_CCW   = 3'd3,
    S_P2    = 3'd4,
    S_GUARD = 3'd5
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] timer_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic             done_q;
  logic             spin_q;
  logic [CNT_W-1:0] cw_q, ccw_q, pause_q;
  logic [REP_W-1:0] rep_q;
`ifdef ROT_SEQ_REV_GUARD_EN
  state_t           tgt_q, tgt_nxt;
`endif

  logic             accept, rep_inc, rep_one, job_fin, wraps;
  logic             empty_in, last_rep, phase_end;
  logic [CNT_W-1:0] cur_len;
  state_t           entry_in, cw_entry, rep_wrap, p2_entry, ccw_entry;
  logic             p2_wraps, ccw_wraps;

  assign empty_in = spin ? (cw_len == '0)
                         : ((rep_num == '0) || ((cw_len == '0) && (ccw_len == '0)));
  assign entry_in = (spin || (cw_len != '0)) ? S_CW
                  : ((pause_len != '0) ? S_P1 : S_CCW);

  // Zero-length phases are chained past combinationally; a non-empty job always
  // has a non-zero CW or CCW phase, so the chain terminates within one repetition.
  assign last_rep  = (rep_cnt_q + REP_W'(1)) == rep_q;
  assign cw_entry  = (cw_q != '0) ? S_CW : ((pause_q != '0) ? S_P1 : S_CCW);
  assign rep_wrap  = last_rep ? S_IDLE : cw_entry;
  assign p2_entry  = (pause_q != '0) ? S_P2 : rep_wrap;
  assign p2_wraps  = (pause_q == '0);
  assign ccw_entry = (ccw_q != '0) ? S_CCW : p2_entry;
  assign ccw_wraps = (ccw_q == '0) && p2_wraps;

  always_comb begin
    cur_len = '0;
    case (state_q)
      S_CW:        cur_len = cw_q;
      S_CCW:       cur_len = ccw_q;
      S_P1, S_P2:  cur_len = pause_q;
      default:     cur_len = '0;
    endcase
  end

  assign phase_end = (timer_q == (cur_len - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      rep_cnt_q <= '0;
      done_q    <= 1'b0;
      spin_q    <= 1'b0;
      cw_q      <= '0;
      ccw_q     <= '0;
      pause_q   <= '0;
      rep_q     <= '0;
`ifdef ROT_SEQ_REV_GUARD_EN
      tgt_q     <= S_IDLE;
`endif
    end else begin
      state_q <= state_nxt;
      done_q  <= job_fin;
      if ((state_q == S_IDLE) || phase_end || (state_nxt != state_q))
        timer_q <= '0;
      else
        timer_q <= timer_q + CNT_W'(1);
      if (accept)
        rep_cnt_q <= '0;
      else if (rep_one)
        rep_cnt_q <= REP_W'(1);
      else if (rep_inc)
        rep_cnt_q <= rep_cnt_q + REP_W'(1);
      if (accept) begin
        spin_q  <= spin;
        cw_q    <= cw_len;
        ccw_q   <= ccw_len;
        pause_q <= pause_len;
        rep_q   <= rep_num;
      end
`ifdef ROT_SEQ_REV_GUARD_EN
      tgt_q <= tgt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    rep_one   = 1'b0;
    job_fin   = 1'b0;
    wraps     = 1'b0;
    rep_inc   = 1'b0;
`ifdef ROT_SEQ_REV_GUARD_EN
    tgt_nxt   = tgt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          accept = 1'b1;
          if (empty_in) job_fin = 1'b1;
          else          state_nxt = entry_in;
        end
      end
      S_CW: begin
        if (phase_end) begin
          if (spin_q) begin
            state_nxt = S_IDLE;
            rep_one   = 1'b1;
            job_fin   = 1'b1;
          end else begin
            state_nxt = (pause_q != '0) ? S_P1 : ccw_entry;
            wraps     = (pause_q == '0) && ccw_wraps;
          end
        end
      end
      S_P1: begin
        if (phase_end) begin
          state_nxt = ccw_entry;
          wraps     = ccw_wraps;
        end
      end
      S_CCW: begin
        if (phase_end) begin
          state_nxt = p2_entry;
          wraps     = p2_wraps;
        end
      end
      S_P2: begin
        if (phase_end) begin
          state_nxt = rep_wrap;
          wraps     = 1'b1;
        end
      end
`ifdef ROT_SEQ_REV_GUARD_EN
      S_GUARD: state_nxt = tgt_q;
`endif
      default: state_nxt = S_IDLE;
    endcase

    rep_inc = wraps;
    if (wraps && last_rep) job_fin = 1'b1;

`ifdef ROT_SEQ_REV_GUARD_EN
    if (((state_q == S_CW) && (state_nxt == S_CCW)) ||
        ((state_q == S_CCW) && (state_nxt == S_CW))) begin
      tgt_nxt   = state_nxt;
      state_nxt = S_GUARD;
    end
`endif

    if (abort && (state_q != S_IDLE)) begin
      state_nxt = S_IDLE;
      rep_inc   = 1'b0;
      rep_one   = 1'b0;
      job_fin   = 1'b0;
    end
  end

  always_comb begin
    motor = '0;
    case (state_q)
      S_CW:    motor = MOTOR_W'(2'b01);
      S_CCW:   motor = MOTOR_W'(2'b10);
      default: motor = '0;
    endcase
    busy    = (state_q != S_IDLE);
    done    = done_q;
    rep_cnt = rep_cnt_q;
  end

endmodule
